// File: rtl/riscv_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Purpose  : Shared types and constants for the pipeline memory path:
//             arbiter state encoding, the NOP instruction and major opcodes.
//  Revision : 1.0  initial release
// ============================================================================
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OP_R      = 7'd51;
    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_IMM    = 7'd19;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_BRANCH = 7'd99;

endpackage
`default_nettype wire

// File: rtl/arb_wait_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : arb_wait_timer
//  Purpose  : Counts cycles spent waiting for a memory acknowledge and flags
//             a timeout once the count reaches MAX_WAIT-1.
//  Revision : 1.0  initial release
// ============================================================================
module arb_wait_timer #(
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam logic [WAIT_W-1:0] c_LAST = WAIT_W'(MAX_WAIT - 1);

    logic [WAIT_W-1:0] r_cnt;

    // Wait counter: cleared on a new grant, holds at the timeout value so it
    // can never wrap while an access is stuck.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != c_LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign timeout = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-ported memory between instruction fetch and
//             the MEM-stage load/store path. Data normally wins, but a
//             starvation counter forces a pending fetch through, and a
//             watchdog completes any access the memory never acknowledges.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_WAIT     = 16,
    parameter int WAIT_W       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        bus_err
);

    localparam int               c_SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_SW-1:0]  c_STARVE_MAX = c_SW'(STARVE_LIMIT);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic [c_SW-1:0]  r_starve_cnt;
    logic             w_data_pend;
    logic             w_grant_d;
    logic             w_grant_i;
    logic             w_done_ack;
    logic             w_done_to;
    logic             w_busy;
    logic             w_timeout;

    assign w_data_pend = d_read | d_write;
    assign w_busy      = (r_state != IDLE);

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = w_data_pend & ~d_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grant and completion decisions. A grant is withheld while a ready pulse
    // is visible so a requester still holding its request is not re-served.
    always_comb begin
        w_state_next = r_state;
        w_grant_d    = 1'b0;
        w_grant_i    = 1'b0;
        w_done_ack   = 1'b0;
        w_done_to    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!(if_ready || d_ready)) begin
                    if (w_data_pend && (!if_req || (r_starve_cnt < c_STARVE_MAX))) begin
                        w_grant_d    = 1'b1;
                        w_state_next = BUSY_D;
                    end else if (if_req) begin
                        w_grant_i    = 1'b1;
                        w_state_next = BUSY_I;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    w_done_ack   = 1'b1;
                    w_state_next = IDLE;
                end else if (w_timeout) begin
                    w_done_to    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Starvation counter: data grants made while a fetch waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (!if_req || w_grant_i) begin
            r_starve_cnt <= '0;
        end else if (w_grant_d && (r_starve_cnt != c_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    arb_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_grant_d | w_grant_i),
        .en      (w_busy & ~mem_ack),
        .timeout (w_timeout)
    );

    // Memory-side request registers, ready pulses and returned data.
    // mem_we is left untouched after completion so the load/store type of the
    // finished access is still known when its result is written back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            bus_err   <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            if (w_grant_d) begin
                mem_req   <= 1'b1;
                mem_addr  <= d_addr;
                mem_we    <= d_write;
                mem_wdata <= d_wdata;
                // Simultaneous read and write is served as a store and flagged.
                if (d_read && d_write) begin
                    bus_err <= 1'b1;
                end
            end
            if (w_grant_i) begin
                mem_req  <= 1'b1;
                mem_addr <= if_addr;
                mem_we   <= 1'b0;
            end
            if (w_done_ack || w_done_to) begin
                mem_req <= 1'b0;
                if (r_state == BUSY_I) begin
                    if_ready <= 1'b1;
                    if_rdata <= w_done_ack ? mem_rdata : NOP_INST;
                end else begin
                    d_ready <= 1'b1;
                    if (!mem_we) begin
                        d_rdata <= w_done_ack ? mem_rdata : 32'h0;
                    end
                end
            end
            if (w_done_to) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench: directed scenarios with literal
//             expectations, then randomized requesters and memory responder
//             compared every cycle against a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;
    import riscv_pkg::*;

    localparam int STARVE_LIMIT = 4;
    localparam int MAX_WAIT     = 16;
    localparam int WAIT_W       = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req, d_read, d_write, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, d_ready, mem_req, mem_we, stall_if, stall_mem, bus_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .MAX_WAIT     (MAX_WAIT),
        .WAIT_W       (WAIT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .bus_err   (bus_err)
    );

    // ------------------------------------------------------------------
    // Transaction model: who owns the memory, how long it has waited, how
    // many data accesses have overtaken a waiting fetch, plus the values the
    // registered outputs must show.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [1:0]  owner;      // 0 none, 1 fetch, 2 data
        logic [7:0]  elapsed;    // edges since the grant
        logic [3:0]  starve;
        logic        req, we, if_ready, d_ready, err;
        logic [31:0] addr, wdata, if_rdata, d_rdata;
    } model_t;

    model_t m;

    function automatic model_t model_step(input model_t s);
        model_t n  = s;
        bit     gd = 1'b0;
        bit     gf = 1'b0;
        n.if_ready = 1'b0;
        n.d_ready  = 1'b0;
        if (s.owner == 2'd0) begin
            if (!(s.if_ready || s.d_ready)) begin
                if ((d_read || d_write) && (!if_req || int'(s.starve) < STARVE_LIMIT)) gd = 1'b1;
                else if (if_req) gf = 1'b1;
            end
            if (gd) begin
                n.owner = 2'd2; n.req = 1'b1; n.addr = d_addr; n.we = d_write;
                n.wdata = d_wdata; n.elapsed = 8'd0;
                if (d_read && d_write) n.err = 1'b1;
            end
            if (gf) begin
                n.owner = 2'd1; n.req = 1'b1; n.addr = if_addr; n.we = 1'b0;
                n.elapsed = 8'd0;
            end
        end else begin
            n.elapsed = s.elapsed + 8'd1;
            if (mem_ack || int'(n.elapsed) == MAX_WAIT) begin
                n.owner = 2'd0;
                n.req   = 1'b0;
                if (!mem_ack) n.err = 1'b1;
                if (s.owner == 2'd1) begin
                    n.if_ready = 1'b1;
                    n.if_rdata = mem_ack ? mem_rdata : 32'h0000_0013;
                end else begin
                    n.d_ready = 1'b1;
                    if (!s.we) n.d_rdata = mem_ack ? mem_rdata : 32'h0;
                end
            end
        end
        if (!if_req || gf) n.starve = 4'd0;
        else if (gd && int'(s.starve) < STARVE_LIMIT) n.starve = s.starve + 4'd1;
        return n;
    endfunction

    // Model advances on the same edges as the design.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_step(m);
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk1 ("mem_req",   mem_req,   m.req);
        chk1 ("if_ready",  if_ready,  m.if_ready);
        chk1 ("d_ready",   d_ready,   m.d_ready);
        chk1 ("bus_err",   bus_err,   m.err);
        chk1 ("stall_if",  stall_if,  if_req & ~m.if_ready);
        chk1 ("stall_mem", stall_mem, (d_read | d_write) & ~m.d_ready);
        chk32("if_rdata",  if_rdata,  m.if_rdata);
        chk32("d_rdata",   d_rdata,   m.d_rdata);
        if (m.req) begin
            chk1 ("mem_we",   mem_we,   m.we);
            chk32("mem_addr", mem_addr, m.addr);
            if (m.we) chk32("mem_wdata", mem_wdata, m.wdata);
        end
    endtask

    // One cycle: wait for the falling edge, then compare against the model.
    task automatic tick();
        @(negedge clk);
        check_all();
    endtask

    int          ndata, nfetch, busy, rsp_wait, rr;
    bit          rsp_active;
    logic [31:0] wv;
    logic [6:0]  opc;

    initial begin
        if_req = 0; d_read = 0; d_write = 0; mem_ack = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        rsp_active = 0; rsp_wait = 0;

        // Reset values
        repeat (3) tick();
        chk1 ("rst_mem_req",  mem_req,  1'b0);
        chk32("rst_if_rdata", if_rdata, 32'h0);
        chk1 ("rst_bus_err",  bus_err,  1'b0);
        rst_n = 1;

        // Fetch only, one-cycle memory
        if_req = 1; if_addr = 32'h100;
        tick();
        chk1 ("t1_req",  mem_req,  1'b1);
        chk1 ("t1_we",   mem_we,   1'b0);
        chk32("t1_addr", mem_addr, 32'h100);
        mem_ack = 1; mem_rdata = 32'h0050_0093;
        tick();
        chk1 ("t1_ready",    if_ready, 1'b1);
        chk32("t1_rdata",    if_rdata, 32'h0050_0093);
        chk1 ("t1_req_drop", mem_req,  1'b0);
        chk1 ("t1_stall",    stall_if, 1'b0);
        mem_ack = 0; if_req = 0;
        tick();
        chk1 ("t1_pulse_len", if_ready, 1'b0);

        // Store and fetch together: store first, fetch after
        if_req = 1; if_addr = 32'h104;
        d_write = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
        tick();
        chk1 ("t2_we",    mem_we,    1'b1);
        chk32("t2_addr",  mem_addr,  32'h2000);
        chk32("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
        mem_ack = 1;
        tick();
        chk1 ("t2_dready",   d_ready,  1'b1);
        chk1 ("t2_stall_if", stall_if, 1'b1);
        mem_ack = 0; d_write = 0;
        tick();
        chk1 ("t2_holdoff",  mem_req,  1'b0);
        chk1 ("t2_stall_if2", stall_if, 1'b1);
        tick();
        chk1 ("t2_fetch_req",  mem_req,  1'b1);
        chk32("t2_fetch_addr", mem_addr, 32'h104);
        mem_ack = 1; mem_rdata = 32'h00A0_0113;
        tick();
        chk1 ("t2_if_ready", if_ready, 1'b1);
        mem_ack = 0; if_req = 0;
        tick();

        // Starvation: loads re-issued continuously while a fetch waits
        if_req = 1; if_addr = 32'h200; d_read = 1; d_addr = 32'h3000;
        ndata = 0; nfetch = 0;
        for (int c = 0; c < 60 && nfetch == 0; c++) begin
            tick();
            if (mem_req) begin
                if (mem_addr == 32'h3000) ndata++; else nfetch++;
                mem_ack = 1; mem_rdata = $urandom | 32'h1;
            end else begin
                mem_ack = 0;
            end
        end
        chk32("t3_data_grants", 32'(ndata),  32'd4);
        chk32("t3_fetch_grant", 32'(nfetch), 32'd1);
        tick();
        mem_ack = 0;
        tick();
        tick();
        chk32("t3_data_after_fetch", mem_addr, 32'h3000);
        mem_ack = 1; if_req = 0;
        tick();
        d_read = 0; mem_ack = 0;
        tick();

        // Unresponsive memory on a load
        d_read = 1; d_addr = 32'h300; busy = 0;
        tick();
        for (int c = 0; c < 40 && mem_req; c++) begin
            busy++;
            tick();
        end
        chk32("t4_busy_cycles", 32'(busy), 32'd16);
        chk1 ("t4_dready",      d_ready,   1'b1);
        chk32("t4_drdata",      d_rdata,   32'h0);
        chk1 ("t4_bus_err",     bus_err,   1'b1);
        d_read = 0;
        repeat (3) tick();
        chk1 ("t4_bus_err_sticky", bus_err, 1'b1);

        // Asynchronous reset during a fetch
        if_req = 1; if_addr = 32'h400;
        tick();
        chk1 ("t5_req", mem_req, 1'b1);
        #2 rst_n = 0;
        #1;
        chk1 ("t5_async_req",  mem_req,  1'b0);
        chk1 ("t5_async_err",  bus_err,  1'b0);
        chk32("t5_async_addr", mem_addr, 32'h0);
        tick();
        rst_n = 1;
        tick();
        chk1 ("t5_no_ready", if_ready, 1'b0);
        chk1 ("t5_regrant",  mem_req,  1'b1);
        chk32("t5_addr",     mem_addr, 32'h400);
        mem_ack = 1; mem_rdata = 32'h0000_0033;
        tick();
        chk1 ("t5_ready", if_ready, 1'b1);
        mem_ack = 0; if_req = 0;
        tick();

        // Read and write together is a store with an error flag
        d_read = 1; d_write = 1; d_addr = 32'h500; d_wdata = 32'h1234_5678;
        tick();
        chk1 ("t6_we",  mem_we,  1'b1);
        chk1 ("t6_err", bus_err, 1'b1);
        mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        chk1 ("t6_dready", d_ready, 1'b1);
        chk32("t6_drdata", d_rdata, 32'h0);
        d_read = 0; d_write = 0; mem_ack = 0;
        tick();
        // Stray acknowledge while idle
        mem_ack = 1;
        repeat (2) begin
            tick();
            chk1("t6_stray_if", if_ready, 1'b0);
            chk1("t6_stray_d",  d_ready,  1'b0);
        end
        mem_ack = 0;

        // Randomized traffic against the model
        rst_n = 0;
        tick();
        rst_n = 1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            if (if_ready || !if_req) begin
                if_req  = ($urandom_range(2) != 0);
                if_addr = $urandom & 32'h0000_FFFC;
            end else if ($urandom_range(63) == 0) begin
                if_req = 0;
            end
            if (d_ready || !(d_read || d_write)) begin
                rr      = $urandom_range(31);
                d_read  = (rr < 10) || (rr == 31);
                d_write = (rr >= 10 && rr < 20) || (rr == 31);
                d_addr  = $urandom & 32'h0000_FFFC;
                d_wdata = $urandom;
            end else if ($urandom_range(63) == 0) begin
                d_read = 0; d_write = 0;
            end
            if (mem_req) begin
                if (!rsp_active) begin
                    rsp_active = 1;
                    rsp_wait   = ($urandom_range(15) == 0) ? 99 : $urandom_range(3);
                end
                if (rsp_wait == 0) begin
                    wv = $urandom;
                    case ($urandom_range(4))
                        0: opc = OP_R;
                        1: opc = OP_LOAD;
                        2: opc = OP_IMM;
                        3: opc = OP_STORE;
                        default: opc = OP_BRANCH;
                    endcase
                    mem_ack   = 1;
                    mem_rdata = {wv[31:7], opc};
                end else begin
                    mem_ack = 0;
                    rsp_wait--;
                end
            end else begin
                rsp_active = 0;
                mem_ack    = ($urandom_range(7) == 0);
                mem_rdata  = $urandom;
            end
            if (cyc == 2000) begin
                #2 rst_n = 0;
                #4 rst_n = 1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound
    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete, actual=running required=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule
`default_nettype wire
